z80_bus_bridge: RTL and testbench



---
 rtl/z80_bus_bridge.sv | 175 +++++++++++++++++
 tb/tb_z80_bus_bridge.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/z80_bus_bridge.sv
// z80_bus_bridge: decodes z80 wishbone master cycles to on-chip sync RAM or off-chip wishbone.
// Latency: on-chip ack at T2+RD_WAIT; off-chip ack the cycle after wb_ack_i (min 2 cycles).
// Backpressure: one cycle in flight; the master is held until m_ack_o, m_cyc_i low aborts.
//
// Ports: wb_clk_i/rst_i (sync, active-high) | m_* master side | ram_* on-chip RAM |
//        wb_* off-chip wishbone | tout_o sticky timeout flag, tout_clr_i clears it.
// Optional: define Z80_BUS_TIMEOUT_EN to enable the off-chip watchdog (TIMEOUT cycles).
module z80_bus_bridge #(
   parameter int ONCHIP_AW = 15,
   parameter int RD_WAIT   = 0,
   parameter int TIMEOUT   = 255
) (
   input  logic                 wb_clk_i,
   input  logic                 rst_i,
   input  logic [15:0]          m_adr_i,
   input  logic [7:0]           m_dat_i,
   input  logic [1:0]           m_tga_i,
   input  logic                 m_we_i,
   input  logic                 m_stb_i,
   input  logic                 m_cyc_i,
   output logic [7:0]           m_dat_o,
   output logic                 m_ack_o,
   output logic                 ram_ce_o,
   output logic                 ram_we_o,
   output logic [ONCHIP_AW-1:0] ram_adr_o,
   output logic [7:0]           ram_dat_o,
   input  logic [7:0]           ram_dat_i,
   output logic [15:0]          wb_adr_o,
   output logic [7:0]           wb_dat_o,
   output logic [1:0]           wb_tga_o,
   output logic                 wb_we_o,
   output logic                 wb_stb_o,
   output logic                 wb_cyc_o,
   input  logic [7:0]           wb_dat_i,
   input  logic                 wb_ack_i,
   output logic                 tout_o,
   input  logic                 tout_clr_i
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RAM  = 2'd1,
      OFF  = 2'd2,
      ACK  = 2'd3
   } state_t;

   state_t      state;
   logic        we_q;       // latched direction, selects read data vs 8'h00 in ACK
   logic        is_ram_q;   // current cycle is on-chip
   logic [7:0]  cap_q;      // off-chip read data (or 8'hFF on timeout)
   logic [15:0] cnt;        // shared wait / timeout counter, saturating
   logic        onchip_hit;

   // Memory-tagged cycles below 2^ONCHIP_AW go to RAM; the shift yields zero for ONCHIP_AW=16.
   always_comb begin
      onchip_hit = (m_tga_i == 2'b00) && ((m_adr_i >> ONCHIP_AW) == 16'd0);
   end

   // On-chip read data comes straight from the RAM output register, valid one cycle after ce.
   always_comb begin
      m_dat_o = 8'h00;
      if (state == ACK && !we_q)
         m_dat_o = is_ram_q ? ram_dat_i : cap_q;
   end

`ifndef Z80_BUS_TIMEOUT_EN
   assign tout_o = 1'b0;
   logic [16:0] unused_cfg;
   assign unused_cfg = {tout_clr_i, 16'(TIMEOUT)};
`endif

   always_ff @(posedge wb_clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         we_q      <= 1'b0;
         is_ram_q  <= 1'b0;
         cap_q     <= 8'h00;
         cnt       <= 16'd0;
         m_ack_o   <= 1'b0;
         ram_ce_o  <= 1'b0;
         ram_we_o  <= 1'b0;
         ram_adr_o <= '0;
         ram_dat_o <= 8'h00;
         wb_adr_o  <= 16'h0000;
         wb_dat_o  <= 8'h00;
         wb_tga_o  <= 2'b00;
         wb_we_o   <= 1'b0;
         wb_stb_o  <= 1'b0;
         wb_cyc_o  <= 1'b0;
`ifdef Z80_BUS_TIMEOUT_EN
         tout_o    <= 1'b0;
`endif
      end else begin
`ifdef Z80_BUS_TIMEOUT_EN
         // A timeout below assigns tout_o later in this block, so a same-cycle set wins.
         if (tout_clr_i)
            tout_o <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (m_cyc_i && m_stb_i) begin
                  we_q <= m_we_i;
                  cnt  <= 16'd0;
                  if (onchip_hit) begin
                     is_ram_q  <= 1'b1;
                     ram_ce_o  <= 1'b1;
                     ram_we_o  <= m_we_i;
                     ram_adr_o <= m_adr_i[ONCHIP_AW-1:0];
                     ram_dat_o <= m_dat_i;
                     state     <= RAM;
                  end else begin
                     is_ram_q <= 1'b0;
                     wb_cyc_o <= 1'b1;
                     wb_stb_o <= 1'b1;
                     wb_adr_o <= m_adr_i;
                     wb_dat_o <= m_dat_i;
                     wb_tga_o <= m_tga_i;
                     wb_we_o  <= m_we_i;
                     state    <= OFF;
                  end
               end
            end

            RAM: begin
               // Strobe only in the first RAM cycle; a write already issued stays done on abort.
               ram_ce_o <= 1'b0;
               ram_we_o <= 1'b0;
               if (!m_cyc_i) begin
                  state <= IDLE;
               end else if (cnt == 16'(RD_WAIT)) begin
                  m_ack_o <= 1'b1;
                  state   <= ACK;
               end else if (cnt != 16'hFFFF) begin
                  cnt <= cnt + 16'd1;
               end
            end

            OFF: begin
               if (!m_cyc_i) begin
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  state    <= IDLE;
               end else if (wb_ack_i) begin
                  cap_q    <= wb_dat_i;
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  m_ack_o  <= 1'b1;
                  state    <= ACK;
               end
`ifdef Z80_BUS_TIMEOUT_EN
               // cnt counts completed OFF cycles; expiry fires in the TIMEOUT-th one.
               else if (cnt == 16'(TIMEOUT - 1)) begin
                  cap_q    <= 8'hFF;
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  tout_o   <= 1'b1;
                  m_ack_o  <= 1'b1;
                  state    <= ACK;
               end else if (cnt != 16'hFFFF) begin
                  cnt <= cnt + 16'd1;
               end
`endif
            end

            ACK: begin
               m_ack_o <= 1'b0;
               state   <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_z80_bus_bridge.sv
// Bench for z80_bus_bridge with ONCHIP_AW=12, RD_WAIT=3, TIMEOUT=8.
// Master transfers push expectations to a scoreboard; results are popped and compared on m_ack_o.
// RAM and wishbone slave are behavioural models; timeout checks exist only with Z80_BUS_TIMEOUT_EN.
module tb_z80_bus_bridge;

   localparam int AW      = 12;
   localparam int WAITS   = 3;
   localparam int LAT_RAM = 2 + WAITS;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [15:0]   m_adr = '0;
   logic [7:0]    m_dat = '0;
   logic [1:0]    m_tga = '0;
   logic          m_we = 1'b0, m_stb = 1'b0, m_cyc = 1'b0;
   logic [7:0]    m_dat_o;
   logic          m_ack_o;
   logic          ram_ce_o, ram_we_o;
   logic [AW-1:0] ram_adr_o;
   logic [7:0]    ram_dat_o;
   logic [7:0]    ram_dat_i = '0;
   logic [15:0]   wb_adr_o;
   logic [7:0]    wb_dat_o;
   logic [1:0]    wb_tga_o;
   logic          wb_we_o, wb_stb_o, wb_cyc_o;
   logic [7:0]    wb_dat_i = '0;
   logic          wb_ack_i = 1'b0;
   logic          tout_o;
   logic          tout_clr = 1'b0;

   z80_bus_bridge #(.ONCHIP_AW(AW), .RD_WAIT(WAITS), .TIMEOUT(8)) dut (
      .wb_clk_i(clk), .rst_i(rst),
      .m_adr_i(m_adr), .m_dat_i(m_dat), .m_tga_i(m_tga),
      .m_we_i(m_we), .m_stb_i(m_stb), .m_cyc_i(m_cyc),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
      .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_adr_o(ram_adr_o),
      .ram_dat_o(ram_dat_o), .ram_dat_i(ram_dat_i),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_tga_o(wb_tga_o),
      .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
      .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
      .tout_o(tout_o), .tout_clr_i(tout_clr)
   );

   always #5 clk = ~clk;

   // Synchronous single-port RAM: read data registered, valid the cycle after ce.
   logic [7:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (ram_ce_o) begin
         if (ram_we_o) mem[ram_adr_o] <= ram_dat_o;
         else          ram_dat_i <= mem[ram_adr_o];
      end
   end

   // Off-chip slave: asserts wb_ack_i during the ack_at-th cycle of wb_stb_o (0 = never).
   int         ack_at = 0;
   int         stb_n = 0;
   logic [7:0] slave_dat = '0;
   always @(posedge clk) begin
      if (!wb_stb_o || wb_ack_i) begin
         stb_n = 0;
         wb_ack_i <= 1'b0;
      end else begin
         stb_n = stb_n + 1;
         wb_ack_i <= (ack_at != 0) && (stb_n + 1 == ack_at);
         wb_dat_i <= slave_dat;
      end
   end

   typedef struct {
      logic [7:0] dat;
      int         lat;
      int         stb;
      logic       tout;
   } exp_t;
   exp_t sb[$];

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {3'b0, m_ack_o, m_dat_o, ram_ce_o, ram_we_o, ram_adr_o, ram_dat_o,
              wb_adr_o, wb_dat_o, wb_tga_o, wb_we_o, wb_stb_o, wb_cyc_o, tout_o};
   endfunction

   // One master transfer; expectations are derived from the arguments and pushed first.
   task automatic xfer(input logic [15:0] adr, input logic [7:0] dat, input logic we,
                       input logic [1:0] tga, input logic onchip, input logic [7:0] rd_exp,
                       input int lat, input int stb, input logic tout_exp);
      exp_t        e;
      int          ce_cnt = 0, ce_at = -1, stb_cnt = 0;
      logic        got = 1'b0, snapped = 1'b0;
      logic [63:0] snap = '0, snap_exp;
      e.dat = we ? 8'h00 : rd_exp;
      e.lat = lat;
      e.stb = stb;
      e.tout = tout_exp;
      sb.push_back(e);
      snap_exp = onchip ? {37'b0, 4'h0, adr[AW-1:0], dat, we, 2'b00}
                        : {37'b0, adr, dat, we, tga};
      @(posedge clk); #1;
      m_adr = adr; m_dat = dat; m_we = we; m_tga = tga; m_cyc = 1'b1; m_stb = 1'b1;
      for (int t = 1; t <= 60 && !got; t++) begin
         @(posedge clk); #1;
         if (ram_ce_o) begin
            ce_cnt++;
            if (ce_at < 0) ce_at = t;
            snap = {37'b0, 4'h0, ram_adr_o, ram_dat_o, ram_we_o, 2'b00};
         end
         if (wb_stb_o) begin
            stb_cnt++;
            if (!snapped) snap = {37'b0, wb_adr_o, wb_dat_o, wb_we_o, wb_tga_o};
            snapped = 1'b1;
         end
         if (m_ack_o) begin
            got = 1'b1;
            e = sb.pop_front();
            chk("ack_latency", 64'(t), 64'(e.lat));
            chk("read_data", 64'(m_dat_o), 64'(e.dat));
            chk("stb_cycles", 64'(stb_cnt), 64'(e.stb));
            chk("tout_flag", 64'(tout_o), 64'(e.tout));
            m_cyc = 1'b0; m_stb = 1'b0;
         end
      end
      if (!got) begin
         e = sb.pop_front();
         chk("ack_missing", 64'(got), 64'(1));
         m_cyc = 1'b0; m_stb = 1'b0;
      end
      chk("ram_ce_count", 64'(ce_cnt), 64'(onchip ? 1 : 0));
      chk("ram_ce_cycle", 64'(ce_at), 64'(onchip ? 1 : -1));
      chk("bus_fields", snap, snap_exp);
      @(posedge clk); #1;
      chk("ack_one_cycle", 64'(m_ack_o), 64'(0));
      chk("dat_idle_zero", 64'(m_dat_o), 64'(0));
   endtask

   initial begin
      int acks;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", all_outs(), 64'(0));
      rst = 1'b0;

      // On-chip writes and read-backs, including the top of the window.
      xfer(16'h0123, 8'h5A, 1'b1, 2'b00, 1'b1, 8'h00, LAT_RAM, 0, 1'b0);
      xfer(16'h0123, 8'h00, 1'b0, 2'b00, 1'b1, 8'h5A, LAT_RAM, 0, 1'b0);
      xfer(16'h0FFF, 8'hA5, 1'b1, 2'b00, 1'b1, 8'h00, LAT_RAM, 0, 1'b0);
      xfer(16'h0FFF, 8'h11, 1'b0, 2'b00, 1'b1, 8'hA5, LAT_RAM, 0, 1'b0);
      xfer(16'h0010, 8'h3C, 1'b1, 2'b00, 1'b1, 8'h00, LAT_RAM, 0, 1'b0);
      xfer(16'h0010, 8'h00, 1'b0, 2'b00, 1'b1, 8'h3C, LAT_RAM, 0, 1'b0);

      // Off-chip: memory above the window, I/O tag, first address past the window.
      ack_at = 4; slave_dat = 8'hC3;
      xfer(16'h8000, 8'h00, 1'b0, 2'b00, 1'b0, 8'hC3, 5, 4, 1'b0);
      ack_at = 2; slave_dat = 8'h96;
      xfer(16'h0005, 8'h00, 1'b0, 2'b01, 1'b0, 8'h96, 3, 2, 1'b0);
      ack_at = 3;
      xfer(16'h1000, 8'h77, 1'b1, 2'b00, 1'b0, 8'h00, 4, 3, 1'b0);

`ifdef Z80_BUS_TIMEOUT_EN
      ack_at = 0;
      xfer(16'h9000, 8'h00, 1'b0, 2'b00, 1'b0, 8'hFF, 9, 8, 1'b1);
      @(posedge clk); #1;
      tout_clr = 1'b1;
      @(posedge clk); #1;
      tout_clr = 1'b0;
      chk("tout_cleared", 64'(tout_o), 64'(0));
`endif
      // Ack in the 8th stb cycle coincides with expiry when the watchdog is on; ack wins.
      ack_at = 8; slave_dat = 8'h42;
      xfer(16'h9001, 8'h00, 1'b0, 2'b10, 1'b0, 8'h42, 9, 8, 1'b0);

      // Abort an off-chip cycle by dropping m_cyc_i.
      ack_at = 0;
      @(posedge clk); #1;
      m_adr = 16'hA000; m_we = 1'b0; m_tga = 2'b00; m_cyc = 1'b1; m_stb = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      m_cyc = 1'b0; m_stb = 1'b0;
      @(posedge clk); #1;
      chk("abort_wb_cyc", 64'({wb_cyc_o, wb_stb_o}), 64'(0));
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         if (m_ack_o) acks++;
         @(posedge clk); #1;
      end
      chk("abort_no_ack", 64'(acks), 64'(0));

      // Reset during the RAM wait states.
      m_adr = 16'h0123; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1; m_cyc = 1'b0; m_stb = 1'b0;
      @(posedge clk); #1;
      chk("reset_mid_ram", all_outs(), 64'(0));
      rst = 1'b0;
      xfer(16'h0123, 8'h00, 1'b0, 2'b00, 1'b1, 8'h5A, LAT_RAM, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
